// File: rtl/msk_ref_sni_pipe_if.sv
// -----------------------------------------------------------------------------
// msk_ref_sni_pipe_if
// Handshake bundle for the SNI refresh pipe: input sharing channel, randomness
// channel and refreshed output channel, each with valid/ready.
//   in_data/in_valid/in_ready    : d*W-bit input sharing, share i at [i*W +: W]
//   rnd/rnd_valid/rnd_ready      : RNDW bits of fresh randomness
//   out_data/out_valid/out_ready : d*W-bit refreshed sharing
// Modports: slave = refresh block view, master = producer/consumer view.
// -----------------------------------------------------------------------------
interface msk_ref_sni_pipe_if #(
    parameter int d = 2,
    parameter int W = 1,
    parameter int L = 1
);
    localparam int RNDW = (d == 1) ? 1 : ((d == 2) ? W : L * d * W);

    logic [d*W-1:0]  in_data;
    logic            in_valid;
    logic            in_ready;
    logic [RNDW-1:0] rnd;
    logic            rnd_valid;
    logic            rnd_ready;
    logic [d*W-1:0]  out_data;
    logic            out_valid;
    logic            out_ready;

    modport slave (
        input  in_data, in_valid, rnd, rnd_valid, out_ready,
        output in_ready, rnd_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, rnd, rnd_valid, out_ready,
        input  in_ready, rnd_ready, out_data, out_valid
    );
endinterface

// File: rtl/msk_ref_sni_pipe.sv
// -----------------------------------------------------------------------------
// msk_ref_sni_pipe
// SNI refresh of a W-bit, d-share Boolean sharing. Randomness is turned into a
// sharing of zero and parked in a one-entry registered mask buffer; the data is
// XORed with that registered mask in a single output register stage.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (clears valid flags only by default)
//   bus : msk_ref_sni_pipe_if.slave (in / rnd / out valid-ready channels)
// Optional build macro MSKREF_SNI_ZEROIZE_EN: reset and consumption also clear
// the data and mask registers so stale shares never linger.
// -----------------------------------------------------------------------------
module msk_ref_sni_pipe #(
    parameter int d = 2,
    parameter int W = 1,
    parameter int L = 1
) (
    input  logic               clk,
    input  logic               rst,
    msk_ref_sni_pipe_if.slave  bus
);
    localparam int DW = d * W;

    logic in_fire, rnd_fire, out_fire;
    logic mask_full;
    logic [DW-1:0] mask_nxt;

    (* keep = "true" *) logic [DW-1:0] mask_q;
    (* keep = "true" *) logic [DW-1:0] out_data_q;
    (* keep = "true" *) logic          out_valid_q;

    assign in_fire  = bus.in_valid  & bus.in_ready;
    assign rnd_fire = bus.rnd_valid & bus.rnd_ready;
    assign out_fire = out_valid_q   & bus.out_ready;

    // Zero-sharing built from randomness only; data never sees rnd directly.
    generate
        if (d == 1) begin : g_mask_d1
            assign mask_nxt = '0;
        end else if (d == 2) begin : g_mask_d2
            assign mask_nxt = {2{bus.rnd[W-1:0]}};
        end else begin : g_mask_ring
            // Each layer XORs r_l with itself rotated by one share, so every
            // random share appears in exactly two output shares.
            always_comb begin
                mask_nxt = '0;
                for (int l = 0; l < L; l++) begin
                    for (int i = 0; i < d; i++) begin
                        mask_nxt[i*W +: W] = mask_nxt[i*W +: W]
                            ^ bus.rnd[(l*d + i)*W +: W]
                            ^ bus.rnd[(l*d + (i + d - 1) % d)*W +: W];
                    end
                end
            end
        end
    endgenerate

    // One-entry mask buffer.
    generate
        if (d == 1) begin : g_buf_d1
            assign mask_full     = 1'b1;
            assign mask_q        = '0;
            assign bus.rnd_ready = 1'b0;
        end else begin : g_buf
            (* keep = "true" *) logic mask_full_q;

            assign mask_full = mask_full_q;
            // Refill allowed in the consuming cycle so streaming has no bubble;
            // an unused mask is never overwritten.
            assign bus.rnd_ready = !mask_full_q | in_fire;

            always_ff @(posedge clk) begin
                if (rst) begin
                    mask_full_q <= 1'b0;
`ifdef MSKREF_SNI_ZEROIZE_EN
                    mask_q      <= '0;
`endif
                end else begin
                    mask_full_q <= rnd_fire | (mask_full_q & !in_fire);
                    if (rnd_fire) begin
                        mask_q <= mask_nxt;
                    end
`ifdef MSKREF_SNI_ZEROIZE_EN
                    else if (in_fire) begin
                        mask_q <= '0;
                    end
`endif
                end
            end
        end
    endgenerate

    // Output register stage.
    assign bus.in_ready  = mask_full & (!out_valid_q | bus.out_ready);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
`ifdef MSKREF_SNI_ZEROIZE_EN
            out_data_q  <= '0;
`endif
        end else if (in_fire) begin
            out_data_q  <= bus.in_data ^ mask_q;
            out_valid_q <= 1'b1;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
`ifdef MSKREF_SNI_ZEROIZE_EN
            out_data_q  <= '0;
`endif
        end
    end
endmodule
